rope_field: RTL and testbench
=============================

Name: rope_field

Overview:
- Upstream stage of the tug-of-war victory logic. Synchronizes and edge-detects the two player keys.
- Tracks the rope position as a single lit LED on the 9-LED playfield (LED9..LED1) and drives the victory stage's inputs: the led9/led1 levels and the L/R press pulses.
- Re-centres the rope when the victory stage reports a win.

Parameters:
- NUM_POS, 9, number of playfield positions (LED1..LED9); fixed at 9 for this board.
- CENTER, 5, position loaded on reset and after a win.
- SYNC_STAGES, 2, synchronizer flops per key input (minimum 2).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- key_l  in  1  raw left-player key, active-high level, asynchronous to Clock.
- key_r  in  1  raw right-player key (human or computer player), active-high level, asynchronous.
- win  in  1  one-cycle win pulse from the victory stage.
- L  out  1  one-cycle left-press pulse to the victory stage.
- R  out  1  one-cycle right-press pulse to the victory stage.
- leds  out  10  playfield LEDs. leds[9]=LED9 … leds[1]=LED1; leds[0] is tied to 0. Exactly one of leds[9:1] is high.

Behaviour:
- Position register pos, range 1..9. leds[i] = (pos == i) for i = 1..9.
- Reset (synchronous, priority over everything):
  - pos <= CENTER, so leds = 10'b0000100000.
  - All synchronizer flops and previous-value flops <= 0.
  - L = R = 0 during reset.
- Synchronizer and edge detect, per key:
  - SYNC_STAGES-flop chain; s = last stage; prev <= s every cycle.
  - L = s_l & ~prev_l. R = s_r & ~prev_r.
  - A held key produces exactly one pulse. A key held through reset release produces one pulse after the sync latency.
- Latency, with SYNC_STAGES=2 and key rising before edge k:
  - s high after edge k+1.
  - L/R high for the single cycle between edges k+1 and k+2.
  - pos updated at edge k+2.
- Position update each non-reset edge, in priority order:
  1. win=1 -> pos <= CENTER. Any same-cycle press is discarded.
  2. L=1 and R=1 -> presses cancel, pos unchanged.
  3. L=1 only -> pos <= pos+1, saturating at 9.
  4. R=1 only -> pos <= pos-1, saturating at 1.
  5. Otherwise -> hold.
- Saturation is intentional. With pos=9, a further L press leaves pos at 9; that press plus led9 is what the victory stage uses to declare the left player the winner. pos=1 with an R press is symmetric.
- Win sequence: the victory stage registers the win one cycle after the press, and win pulses in the following cycle. At the next edge this block re-centres to 5.
- Mid-game Reset: pos returns to CENTER on the same edge; any in-flight press pulse is lost.
- pos must never leave 1..9. Add an assertion: exactly one bit of leds[9:1] set, and leds[0]=0, whenever not in reset.

Decomposition:
- Package tow_pkg holds:
  - NUM_POS, CENTER
  - typedef pos_t (logic [3:0])
  - move_e enum {HOLD, MOVE_L, MOVE_R, RECENTER} for the next-position decode.
- Sub-module key_edge (Clock, Reset, raw, pulse): synchronizer chain plus rising-edge detect, parameterised by SYNC_STAGES. Instantiated twice, for key_l and key_r.
- Position register and decode live in rope_field itself.

Test Plan:
- Reset for 2 cycles, then release -> leds = 10'b0000100000, L = R = 0.
- key_l rises and is held 10 cycles -> one L pulse 2 cycles after the edge; pos 5->6 one cycle later; leds[6]=1 and no further movement while held.
- Five separate key_l presses from centre -> pos 6,7,8,9,9.
  - The 5th press still pulses L with leds[9]=1.
  - Assert win one cycle after that pulse -> pos=5 on the next edge.
- key_l and key_r rise on the same cycle -> L and R pulse together, pos stays 5. Then 4 key_r presses -> pos 4,3,2,1. A 5th press -> pos stays 1, R pulses.
- win and an L pulse in the same cycle with pos=7 -> pos=5; the press is ignored.
- pos=8, assert Reset for one cycle while key_r is mid-synchronizer -> pos=5 after that edge, no R pulse during reset, at most one R pulse afterwards if key_r is still high.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war playfield: board geometry, the
// rope position type and the next-position decode used by rope_field.
package tow_pkg;

  localparam int NUM_POS             = 9;
  localparam int CENTER              = 5;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef logic [3:0] pos_t;

  typedef enum logic [1:0] {
    HOLD,
    MOVE_L,
    MOVE_R,
    RECENTER
  } move_e;

endpackage

// File: rtl/rope_field_key_edge.sv
// Brings one raw player key into the Clock domain through a flop chain and
// turns each rising edge of the synchronised level into a one-cycle pulse.
// The pulse is forced low while Reset is asserted so no press escapes
// during reset.
module key_edge
  import tow_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  // Shift the raw level one stage further into the chain each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Synchroniser chain plus the previous-value flop for edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q & ~Reset;

endmodule

// File: rtl/rope_field.sv
// Upstream stage of the tug-of-war victory logic: turns the two player keys
// into L/R press pulses, moves the rope (one lit LED among LED9..LED1) and
// re-centres it when the victory stage reports a win.
module rope_field
  import tow_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             key_l,
  input  logic             key_r,
  input  logic             win,
  output logic             L,
  output logic             R,
  output logic [NUM_POS:0] leds
);

  localparam pos_t CENTER_POS = pos_t'(CENTER);
  localparam pos_t MAX_POS    = pos_t'(NUM_POS);
  localparam pos_t MIN_POS    = pos_t'(1);

  pos_t  pos_q;
  pos_t  pos_d;
  move_e move;

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_l (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (key_l),
    .pulse (L)
  );

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_r (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (key_r),
    .pulse (R)
  );

  // Decide this cycle's move: a win beats everything, simultaneous presses cancel.
  always_comb begin
    move = HOLD;
    if (win) begin
      move = RECENTER;
    end else if (L && !R) begin
      move = MOVE_L;
    end else if (R && !L) begin
      move = MOVE_R;
    end
  end

  // Next rope position; the ends saturate so the victory stage can see a press at the edge.
  always_comb begin
    pos_d = pos_q;
    case (move)
      RECENTER: pos_d = CENTER_POS;
      MOVE_L:   if (pos_q < MAX_POS) pos_d = pos_q + pos_t'(1);
      MOVE_R:   if (pos_q > MIN_POS) pos_d = pos_q - pos_t'(1);
      default:  pos_d = pos_q;
    endcase
  end

  // Rope position register, centred by reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pos_q <= CENTER_POS;
    end else begin
      pos_q <= pos_d;
    end
  end

  // One-hot LED image of the rope position; LED0 is not part of the playfield.
  always_comb begin
    leds = '0;
    for (int i = 1; i <= NUM_POS; i++) begin
      leds[i] = (pos_q == pos_t'(i));
    end
  end

  // The rope must always be exactly one lit playfield LED outside reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      assert ($onehot(leds[NUM_POS:1]) && (leds[0] == 1'b0));
    end
  end

endmodule

// File: tb/tb_rope_field.sv
// Randomised and directed bench for rope_field. A reference model records the
// key level sampled at every clock edge and derives the press pulses and rope
// position from those histories with plain arithmetic.
module tb_rope_field;

  logic       Clock;
  logic       Reset;
  logic       key_l;
  logic       key_r;
  logic       win;
  logic       L;
  logic       R;
  logic [9:0] leds;

  int checks = 0;
  int errors = 0;

  // model state
  bit klArr [0:4095];
  bit krArr [0:4095];
  int edgeNum   = 0;
  int lastReset = -100;
  int modelPos  = 5;
  bit expL      = 1'b0;
  bit expR      = 1'b0;
  bit curReset  = 1'b1;

  rope_field dut (
    .Clock (Clock),
    .Reset (Reset),
    .key_l (key_l),
    .key_r (key_r),
    .win   (win),
    .L     (L),
    .R     (R),
    .leds  (leds)
  );

  // free-running clock, period 10
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // key level as seen by the synchroniser at edge j (cleared by the last reset)
  function automatic bit lvl(bit isLeft, int j);
    if (j < 0 || j <= lastReset) return 1'b0;
    return isLeft ? klArr[j] : krArr[j];
  endfunction

  function automatic logic [9:0] ledsOf(int p);
    logic [9:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // compare outputs with the model, drive one cycle of inputs, advance the model over the edge
  task automatic applyStimulus(input bit kl, input bit kr, input bit w, input bit rst);
    @(negedge Clock);
    if (edgeNum > 0) begin
      checkOutput("L", {9'b0, L}, {9'b0, expL});
      checkOutput("R", {9'b0, R}, {9'b0, expR});
      checkOutput("leds", leds, ledsOf(modelPos));
    end
    key_l = kl;
    key_r = kr;
    win   = w;
    Reset = rst;
    @(posedge Clock);
    klArr[edgeNum] = kl;
    krArr[edgeNum] = kr;
    if (rst) begin
      lastReset = edgeNum;
      modelPos  = 5;
    end else if (w) begin
      modelPos = 5;
    end else if (expL && !expR) begin
      modelPos = (modelPos < 9) ? modelPos + 1 : 9;
    end else if (expR && !expL) begin
      modelPos = (modelPos > 1) ? modelPos - 1 : 1;
    end
    curReset = rst;
    expL = !curReset && lvl(1'b1, edgeNum - 1) && !lvl(1'b1, edgeNum - 2);
    expR = !curReset && lvl(1'b0, edgeNum - 1) && !lvl(1'b0, edgeNum - 2);
    edgeNum++;
  endtask

  task automatic pressKey(input bit left, input bit right, input bit winAfter);
    repeat (3) applyStimulus(left, right, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, winAfter, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    key_l = 1'b0;
    key_r = 1'b0;
    win   = 1'b0;
    Reset = 1'b1;

    // reset for two cycles, then release
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("resetLeds", leds, 10'b0000100000);
    checkOutput("resetLR", {8'b0, L, R}, 10'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // held key gives a single step
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("heldStep", leds, 10'b0001000000);

    // back to centre, then five left presses; win follows the saturating one
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) pressKey(1'b1, 1'b0, 1'b0);
    #1 checkOutput("satLeft", leds, 10'b1000000000);
    pressKey(1'b1, 1'b0, 1'b1);
    #1 checkOutput("winCentre", leds, 10'b0000100000);

    // simultaneous presses cancel, then walk right into saturation
    pressKey(1'b1, 1'b1, 1'b0);
    #1 checkOutput("cancel", leds, 10'b0000100000);
    repeat (5) pressKey(1'b0, 1'b1, 1'b0);
    #1 checkOutput("satRight", leds, 10'b0000000010);

    // win coinciding with an L pulse at pos 7
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) pressKey(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("winBeatsL", leds, 10'b0000100000);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // mid-game reset at pos 8 while key_r is inside the synchroniser
    repeat (3) pressKey(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("midReset", leds, 10'b0000100000);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // randomised play
    begin
      bit kl = 1'b0;
      bit kr = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) kl = ~kl;
        if ($urandom_range(0, 3) == 0) kr = ~kr;
        applyStimulus(kl, kr, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
